// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, output register plus
// a 1-entry skid, and squash of in-flight fetches on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    output logic        fin,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        valid
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] pc_nxt, instr_nxt;
    logic        valid_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic        squash, squash_nxt;

    assign fin = valid;

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        pc_nxt         = pc;
        instr_nxt      = instr;
        valid_nxt      = valid;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        squash_nxt     = squash;

        // Decode takes the current word; any load below overrides this.
        if (valid && !stall) begin
            valid_nxt = 1'b0;
            instr_nxt = NOP_INSTR;
        end

        case (state)
            S_IDLE: if (enable) state_nxt = S_REQ;
            S_REQ:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_ack) begin
                    if (squash) begin
                        squash_nxt = 1'b0;
                        state_nxt  = S_REQ;
                    end else if (!valid || !stall) begin
                        pc_nxt       = fetch_pc;
                        instr_nxt    = imem_rdata;
                        valid_nxt    = 1'b1;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        state_nxt    = enable ? S_REQ : S_IDLE;
                    end else begin
                        skid_pc_nxt    = fetch_pc;
                        skid_instr_nxt = imem_rdata;
                        fetch_pc_nxt   = fetch_pc + 32'd4;
                        state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    pc_nxt    = skid_pc;
                    instr_nxt = skid_instr;
                    valid_nxt = 1'b1;
                    state_nxt = enable ? S_REQ : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Redirect wins over stall and over any ack load above.
        if (redirect) begin
            valid_nxt      = 1'b0;
            instr_nxt      = NOP_INSTR;
            skid_pc_nxt    = 32'h0;
            skid_instr_nxt = 32'h0;
            fetch_pc_nxt   = redirect_pc & 32'hFFFF_FFFC;
            case (state)
                S_REQ: begin
                    state_nxt  = S_WAIT;
                    squash_nxt = 1'b1;
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        state_nxt  = S_REQ;
                        squash_nxt = 1'b0;
                    end else begin
                        state_nxt  = S_WAIT;
                        squash_nxt = 1'b1;
                    end
                end
                default: state_nxt = enable ? S_REQ : S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            fetch_pc   <= RESET_PC;
            pc         <= RESET_PC;
            instr      <= NOP_INSTR;
            valid      <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            skid_pc    <= 32'h0;
            skid_instr <= 32'h0;
            squash     <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            pc         <= pc_nxt;
            instr      <= instr_nxt;
            valid      <= valid_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
            squash     <= squash_nxt;
            // imem_req is high exactly while in REQ; the address is only
            // captured on entry so it stays put until the ack.
            imem_req   <= (state_nxt == S_REQ);
            if (state_nxt == S_REQ)
                imem_addr <= fetch_pc_nxt;
        end
    end

endmodule
